// File: rtl/s2p_pkg.sv
// rtl/s2p_pkg.sv - shared state encoding and default comma for the s2p framing controller
package s2p_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } s2p_state_e;

    localparam logic [7:0] S2P_COM_DEF = 8'hBC;

endpackage

// File: rtl/s2p_shift_reg.sv
// rtl/s2p_shift_reg.sv - enabled MSB-first shift register exposing stored and post-shift windows
module s2p_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             i_en,
    input  logic             i_din,
    output logic [WIDTH-1:0] o_sr,
    output logic [WIDTH-1:0] o_win
);

    logic [WIDTH-1:0] r_sr;

    // Window as it will look after this bit is shifted in; all compares use it
    assign o_win = {r_sr[WIDTH-2:0], i_din};
    assign o_sr  = r_sr;

    // Shift one bit in whenever the serial strobe is present
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_sr <= '0;
        end else if (i_en) begin
            r_sr <= o_win;
        end
    end

endmodule

// File: rtl/s2p_frame_ctrl.sv
// rtl/s2p_frame_ctrl.sv - comma hunt, byte alignment and lock supervision; S2P_ERRCNT_EN adds err_cnt
module s2p_frame_ctrl
    import s2p_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] COM      = S2P_COM_DEF,
    parameter int               SYNC_CNT = 4,
    parameter int               MAX_GAP  = 16
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             bit_en,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             active
`ifdef S2P_ERRCNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = $clog2(SYNC_CNT + 1);
    localparam int GW = $clog2(MAX_GAP + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [CW-1:0] SYNC_TGT = CW'(SYNC_CNT);
    localparam logic [GW-1:0] GAP_LIM  = GW'(MAX_GAP);

    s2p_state_e       r_state, w_state_nxt;
    logic [BW-1:0]    r_bit_cnt, w_bit_nxt;
    logic [CW-1:0]    r_com_cnt, w_com_nxt;
    logic [GW-1:0]    r_gap_cnt, w_gap_nxt;
    logic [WIDTH-1:0] r_data_out, w_data_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_active, w_active_nxt;
    logic [WIDTH-1:0] w_sr;
    logic [WIDTH-1:0] w_win;
    logic             w_boundary;
    logic             w_is_com;
`ifdef S2P_ERRCNT_EN
    logic [7:0]       r_err_cnt, w_err_nxt;
`endif

    s2p_shift_reg #(.WIDTH(WIDTH)) u_shift_reg (
        .clk     (clk),
        .reset_L (reset_L),
        .i_en    (bit_en),
        .i_din   (data_in),
        .o_sr    (w_sr),
        .o_win   (w_win)
    );

    assign w_boundary = (r_bit_cnt == BIT_LAST);
    assign w_is_com   = (w_win == COM);

    // Next-state, counter and output decisions; nothing moves without bit_en
    always_comb begin
        w_state_nxt  = r_state;
        w_bit_nxt    = r_bit_cnt;
        w_com_nxt    = r_com_cnt;
        w_gap_nxt    = r_gap_cnt;
        w_data_nxt   = r_data_out;
        w_valid_nxt  = 1'b0;
        w_active_nxt = r_active;
`ifdef S2P_ERRCNT_EN
        w_err_nxt    = r_err_cnt;
`endif
        if (bit_en) begin
            w_bit_nxt = w_boundary ? '0 : r_bit_cnt + 1'b1;
            case (r_state)
                SEARCH: begin
                    // A comma at any bit position defines the new byte boundary
                    if (w_is_com) begin
                        w_bit_nxt = '0;
                        w_com_nxt = CW'(1);
                        if (SYNC_CNT == 1) begin
                            w_state_nxt  = LOCKED;
                            w_active_nxt = 1'b1;
                            w_gap_nxt    = '0;
                        end else begin
                            w_state_nxt = ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    if (w_boundary) begin
                        if (w_is_com) begin
                            w_com_nxt = r_com_cnt + 1'b1;
                            if (r_com_cnt + 1'b1 == SYNC_TGT) begin
                                w_state_nxt  = LOCKED;
                                w_active_nxt = 1'b1;
                                w_gap_nxt    = '0;
                            end
                        end else begin
                            w_state_nxt = SEARCH;
                            w_com_nxt   = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (w_boundary) begin
                        if (w_is_com) begin
                            w_gap_nxt = '0;
                        end else if (r_gap_cnt == GAP_LIM) begin
                            // Gap overflow: drop lock and swallow this byte
                            w_state_nxt  = SEARCH;
                            w_active_nxt = 1'b0;
                            w_com_nxt    = '0;
                            w_gap_nxt    = '0;
`ifdef S2P_ERRCNT_EN
                            if (r_err_cnt != 8'hFF) begin
                                w_err_nxt = r_err_cnt + 8'd1;
                            end
`endif
                        end else begin
                            w_data_nxt  = w_win;
                            w_valid_nxt = 1'b1;
                            w_gap_nxt   = r_gap_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = SEARCH;
                end
            endcase
        end
    end

    // State, counters and registered outputs; reset wins over any strobe
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_state    <= SEARCH;
            r_bit_cnt  <= '0;
            r_com_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_active   <= 1'b0;
`ifdef S2P_ERRCNT_EN
            r_err_cnt  <= 8'd0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_com_cnt  <= w_com_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_data_out <= w_data_nxt;
            r_valid    <= w_valid_nxt;
            r_active   <= w_active_nxt;
`ifdef S2P_ERRCNT_EN
            r_err_cnt  <= w_err_nxt;
`endif
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid;
    assign active    = r_active;
`ifdef S2P_ERRCNT_EN
    assign err_cnt   = r_err_cnt;
`endif

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// tb/tb_s2p_frame_ctrl.sv - directed self-checking bench for s2p_frame_ctrl
module tb_s2p_frame_ctrl;

    logic       clk;
    logic       reset_L;
    logic       bit_en;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
`ifdef S2P_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    int n_checks;
    int n_errors;
    int vcnt;
    int vdouble;
    int inactive_seen;
    int stall;
    logic [7:0] last_data;
    logic       prev_valid;

    s2p_frame_ctrl dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .bit_en    (bit_en),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
`ifdef S2P_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count valid pulses and catch any pulse wider than one cycle
    always @(negedge clk) begin
        if (valid_out) begin
            vcnt      = vcnt + 1;
            last_data = data_out;
            if (prev_valid) vdouble = vdouble + 1;
        end
        if (!active) inactive_seen = inactive_seen + 1;
        prev_valid = valid_out;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_en  = 1'b1;
        data_in = b;
        @(posedge clk);
        #1;
        if (stall != 0) begin
            @(negedge clk);
            bit_en = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic idle();
        @(negedge clk);
        bit_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_L = 1'b0;
        bit_en  = 1'b0;
        data_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_L    = 1'b1;
        vcnt       = 0;
        vdouble    = 0;
        prev_valid = 1'b0;
    endtask

    task automatic lock4();
        for (int k = 0; k < 4; k++) send_byte(8'hBC);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; vcnt = 0; vdouble = 0; stall = 0;
        inactive_seen = 0; last_data = 8'h00; prev_valid = 1'b0;
        reset_L = 1'b0; bit_en = 1'b0; data_in = 1'b0;

        // Reset state
        do_reset();
        check("rst_data", {24'd0, data_out}, 32'h00);
        check("rst_valid", {31'd0, valid_out}, 32'h0);
        check("rst_active", {31'd0, active}, 32'h0);
`ifdef S2P_ERRCNT_EN
        check("rst_err", {24'd0, err_cnt}, 32'h0);
`endif

        // Lock: 3 leading bits, four commas, then 5A
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        for (int i = 7; i >= 1; i--) send_bit(1'b0 ^ ((8'hBC >> i) & 1));
        check("lock_pre_last_bit", {31'd0, active}, 32'h0);
        send_bit(1'b0);
        check("lock_active_rise", {31'd0, active}, 32'h1);
        send_byte(8'h5A);
        check("lock_valid", {31'd0, valid_out}, 32'h1);
        check("lock_data", {24'd0, data_out}, 32'h5A);
        idle();
        @(posedge clk); #1;
        check("lock_valid_drop", {31'd0, valid_out}, 32'h0);
        check("lock_vcnt", vcnt, 32'd1);

        // False lock: interrupted comma run must restart the hunt
        do_reset();
        send_byte(8'hBC); send_byte(8'hBC); send_byte(8'h00);
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        check("false_no_lock", {31'd0, active}, 32'h0);
        send_byte(8'hBC);
        check("false_lock", {31'd0, active}, 32'h1);
        send_byte(8'h33);
        idle();
        @(posedge clk); #1;
        check("false_data", {24'd0, data_out}, 32'h33);
        check("false_vcnt", vcnt, 32'd1);

        // Gap loss: 17 non-comma bytes, the 17th is swallowed
        do_reset();
        lock4();
        for (int k = 1; k <= 16; k++) send_byte(k[7:0]);
        check("gap_active_16", {31'd0, active}, 32'h1);
        send_byte(8'h11);
        check("gap_active_fall", {31'd0, active}, 32'h0);
        idle();
        @(posedge clk); #1;
        check("gap_vcnt", vcnt, 32'd16);
        check("gap_last_data", {24'd0, last_data}, 32'h10);
        check("gap_data_hold", {24'd0, data_out}, 32'h10);
`ifdef S2P_ERRCNT_EN
        check("gap_err", {24'd0, err_cnt}, 32'h1);
`endif

        // Gap reset: a comma mid-run restarts the gap count
        do_reset();
        lock4();
        inactive_seen = 0;
        for (int k = 0; k < 10; k++) send_byte(8'h20 + k[7:0]);
        send_byte(8'hBC);
        for (int k = 0; k < 10; k++) send_byte(8'h40 + k[7:0]);
        check("gapr_active", {31'd0, active}, 32'h1);
        idle();
        @(posedge clk); #1;
        check("gapr_never_drop", inactive_seen, 32'd0);
        check("gapr_vcnt", vcnt, 32'd20);
        check("gapr_last", {24'd0, last_data}, 32'h49);

        // Stalled strobe: bit_en 1-0-0 between bits
        do_reset();
        stall = 1;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        lock4();
        check("stall_active", {31'd0, active}, 32'h1);
        for (int i = 7; i >= 1; i--) send_bit(((8'h5A >> i) & 1) != 0);
        @(negedge clk);
        bit_en  = 1'b1;
        data_in = 1'b0;
        @(posedge clk); #1;
        bit_en = 1'b0;
        check("stall_valid", {31'd0, valid_out}, 32'h1);
        check("stall_data", {24'd0, data_out}, 32'h5A);
        @(posedge clk); #1;
        check("stall_valid_drop", {31'd0, valid_out}, 32'h0);
        stall = 0;
        repeat (2) @(posedge clk);
        #1;
        check("stall_vcnt", vcnt, 32'd1);
        check("stall_width", vdouble, 32'd0);

        // Reset mid-byte while locked
        do_reset();
        lock4();
        send_byte(8'h77);
        check("mid_pre_data", {24'd0, data_out}, 32'h77);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        @(negedge clk);
        reset_L = 1'b0;
        bit_en  = 1'b1;
        data_in = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_data", {24'd0, data_out}, 32'h00);
        check("mid_rst_active", {31'd0, active}, 32'h0);
        check("mid_rst_valid", {31'd0, valid_out}, 32'h0);
        @(negedge clk);
        reset_L = 1'b1;
        bit_en  = 1'b0;
        vcnt    = 0;
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        send_byte(8'h44);
        check("mid_no_valid", vcnt, 32'd0);
        lock4();
        send_byte(8'h55);
        idle();
        @(posedge clk); #1;
        check("mid_relock_vcnt", vcnt, 32'd1);
        check("mid_relock_data", {24'd0, data_out}, 32'h55);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard time bound so the bench never hangs
    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
